// File: rtl/led_matrix_face_player_if.sv
// Pin bundle between the end-of-game face player and the board top level:
// the two result triggers in, the matrix/buzzer drive and handshake out.
interface led_matrix_face_player_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic            success;
    logic            fail;
    logic [ROWS-1:0] hang;
    logic [COLS-1:0] gre;
    logic            beep;
    logic            repeat_rst;
    logic            busy;

    modport master (
        output success, fail,
        input  hang, gre, beep, repeat_rst, busy
    );

    modport slave (
        input  success, fail,
        output hang, gre, beep, repeat_rst, busy
    );
endinterface

// File: rtl/led_matrix_face_player.sv
// End-of-game player: scans a win/lose face onto a row-scanned LED matrix,
// beeps a mode-specific tone, then requests a game restart via repeat_rst.
module led_matrix_face_player #(
    parameter int                   ROWS           = 8,
    parameter int                   COLS           = 8,
    parameter logic [ROWS*COLS-1:0] WIN_PATTERN    = 64'h0066666600422418,
    parameter logic [ROWS*COLS-1:0] LOSE_PATTERN   = 64'h0066666600182442,
    parameter int                   SCAN_DIV       = 1,
    parameter int                   WIN_BEEP_DIV   = 10,
    parameter int                   LOSE_BEEP_DIV  = 23,
    parameter int                   HOLD_CYCLES    = 2500,
    parameter int                   ROW_ACTIVE_LOW = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    led_matrix_face_player_if.slave  io
);

    typedef enum logic [1:0] {
        IDLE,
        SHOW_WIN,
        SHOW_LOSE,
        DONE
    } state_t;

    localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BEEP_MAX = (WIN_BEEP_DIV > LOSE_BEEP_DIV) ? WIN_BEEP_DIV : LOSE_BEEP_DIV;
    localparam int BEEP_W   = (BEEP_MAX > 0) ? $clog2(BEEP_MAX + 1) : 1;
    localparam int HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BEEP_W-1:0] WIN_DIV   = BEEP_W'(WIN_BEEP_DIV);
    localparam logic [BEEP_W-1:0] LOSE_DIV  = BEEP_W'(LOSE_BEEP_DIV);
    localparam logic [ROWS-1:0]   ROW_ONE   = ROWS'(1);
    localparam logic [ROWS-1:0]   HANG_OFF  = (ROW_ACTIVE_LOW != 0) ? {ROWS{1'b1}} : '0;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [SCAN_W-1:0]  scan_q, scan_d;
    logic [BEEP_W-1:0]  beep_cnt_q, beep_cnt_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [ROWS-1:0]    hang_q, hang_d;
    logic [COLS-1:0]    gre_q, gre_d;
    logic               beep_q, beep_d;
    logic               repeat_q, repeat_d;
    logic               lose;
    logic [BEEP_W-1:0]  div;

    // Row r lights physical line ROWS-1-r, so row 0 sits on the MSB of hang.
    function automatic logic [ROWS-1:0] row_drive(input logic [ROW_W-1:0] r);
        logic [ROWS-1:0] one_hot;
        one_hot = ROW_ONE << (ROWS - 1 - int'(r));
        return (ROW_ACTIVE_LOW != 0) ? ~one_hot : one_hot;
    endfunction

    function automatic logic [COLS-1:0] row_pixels(input logic lose_mode,
                                                   input logic [ROW_W-1:0] r);
        logic [ROWS*COLS-1:0] shifted;
        shifted = (lose_mode ? LOSE_PATTERN : WIN_PATTERN) >> ((ROWS - 1 - int'(r)) * COLS);
        return shifted[COLS-1:0];
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        row_d      = row_q;
        scan_d     = scan_q;
        beep_cnt_d = beep_cnt_q;
        hold_d     = hold_q;
        hang_d     = HANG_OFF;
        gre_d      = '0;
        beep_d     = 1'b0;
        repeat_d   = 1'b0;
        lose       = (state_q == SHOW_LOSE);
        div        = lose ? LOSE_DIV : WIN_DIV;

        case (state_q)
            IDLE: begin
                row_d      = '0;
                scan_d     = '0;
                beep_cnt_d = '0;
                hold_d     = '0;
                if (io.success || io.fail) begin
                    state_d = io.success ? SHOW_WIN : SHOW_LOSE;
                    hang_d  = row_drive('0);
                    gre_d   = row_pixels(!io.success, '0);
                end
            end

            SHOW_WIN, SHOW_LOSE: begin
                if (hold_q == HOLD_LAST) begin
                    state_d    = DONE;
                    repeat_d   = 1'b1;
                    row_d      = '0;
                    scan_d     = '0;
                    beep_cnt_d = '0;
                    hold_d     = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);

                    if (scan_q == SCAN_LAST) begin
                        scan_d = '0;
                        row_d  = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                    end else begin
                        scan_d = scan_q + SCAN_W'(1);
                    end

                    if (beep_cnt_q == div) begin
                        beep_cnt_d = '0;
                        beep_d     = ~beep_q;
                    end else begin
                        beep_cnt_d = beep_cnt_q + BEEP_W'(1);
                        beep_d     = beep_q;
                    end

                    hang_d = row_drive(row_d);
                    gre_d  = row_pixels(lose, row_d);
                end
            end

            DONE: begin
                // Hold the restart request until the top level has released both triggers.
                repeat_d = 1'b1;
                if (!io.success && !io.fail) begin
                    state_d  = IDLE;
                    repeat_d = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            scan_q     <= '0;
            beep_cnt_q <= '0;
            hold_q     <= '0;
            hang_q     <= HANG_OFF;
            gre_q      <= '0;
            beep_q     <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            scan_q     <= scan_d;
            beep_cnt_q <= beep_cnt_d;
            hold_q     <= hold_d;
            hang_q     <= hang_d;
            gre_q      <= gre_d;
            beep_q     <= beep_d;
            repeat_q   <= repeat_d;
        end
    end

    assign io.hang       = hang_q;
    assign io.gre        = gre_q;
    assign io.beep       = beep_q;
    assign io.repeat_rst = repeat_q;
    assign io.busy       = (state_q != IDLE);

    // Exactly one row lit while a face is showing; restart request only from DONE.
    assert property (@(posedge clk) disable iff (rst)
        (state_q == SHOW_WIN || state_q == SHOW_LOSE)
            |-> $onehot((ROW_ACTIVE_LOW != 0) ? ~hang_q : hang_q));

    assert property (@(posedge clk) disable iff (rst)
        repeat_q |-> (state_q == DONE));

endmodule

// File: tb/tb_led_matrix_face_player.sv
// Scoreboard bench for led_matrix_face_player: expected pin traces are queued
// when a trigger is driven and compared cycle by cycle against three configurations.
module tb_led_matrix_face_player;

    typedef struct packed {
        logic [7:0] hang;
        logic [7:0] gre;
        logic       beep;
        logic       rep;
        logic       busy;
    } obs_t;

    typedef struct {
        int          rows;
        int          cols;
        int          scan;
        int          div;
        int          hold;
        bit          active_low;
        logic [63:0] pattern;
    } cfg_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    obs_t sb[$];

    always #5 clk = ~clk;

    led_matrix_face_player_if #(.ROWS(8), .COLS(8)) bus_a ();
    led_matrix_face_player_if #(.ROWS(8), .COLS(8)) bus_b ();
    led_matrix_face_player_if #(.ROWS(4), .COLS(6)) bus_c ();

    led_matrix_face_player dut_a (
        .clk (clk),
        .rst (rst),
        .io  (bus_a)
    );

    led_matrix_face_player #(
        .HOLD_CYCLES   (40),
        .SCAN_DIV      (2),
        .LOSE_BEEP_DIV (3)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .io  (bus_b)
    );

    led_matrix_face_player #(
        .ROWS           (4),
        .COLS           (6),
        .ROW_ACTIVE_LOW (0),
        .WIN_PATTERN    (24'hFC003F),
        .LOSE_PATTERN   (24'h0C030C),
        .SCAN_DIV       (1),
        .HOLD_CYCLES    (30)
    ) dut_c (
        .clk (clk),
        .rst (rst),
        .io  (bus_c)
    );

    // Independent configuration records for the expected-value model.
    cfg_t a_win  = '{rows: 8, cols: 8, scan: 1, div: 10, hold: 2500, active_low: 1'b1, pattern: 64'h0066666600422418};
    cfg_t b_win  = '{rows: 8, cols: 8, scan: 2, div: 10, hold: 40,   active_low: 1'b1, pattern: 64'h0066666600422418};
    cfg_t b_lose = '{rows: 8, cols: 8, scan: 2, div: 3,  hold: 40,   active_low: 1'b1, pattern: 64'h0066666600182442};
    cfg_t c_win  = '{rows: 4, cols: 6, scan: 1, div: 10, hold: 30,   active_low: 1'b0, pattern: 64'h0000000000FC003F};

    function automatic logic [7:0] hang_off(cfg_t c);
        return c.active_low ? 8'((1 << c.rows) - 1) : 8'h00;
    endfunction

    function automatic obs_t idle_exp(cfg_t c);
        obs_t e;
        e.hang = hang_off(c);
        e.gre  = 8'h00;
        e.beep = 1'b0;
        e.rep  = 1'b0;
        e.busy = 1'b0;
        return e;
    endfunction

    function automatic obs_t done_exp(cfg_t c);
        obs_t e;
        e      = idle_exp(c);
        e.rep  = 1'b1;
        e.busy = 1'b1;
        return e;
    endfunction

    // Pins after the k-th edge following the trigger sample (k = 0 is the trigger edge).
    function automatic obs_t show_exp(cfg_t c, int k);
        obs_t        e;
        int          row;
        logic [7:0]  sel;
        logic [63:0] pat;
        row = (k / c.scan) % c.rows;
        sel = 8'(1 << (c.rows - 1 - row));
        if (c.active_low) sel = ~sel & hang_off(c);
        pat    = c.pattern >> ((c.rows - 1 - row) * c.cols);
        e.hang = sel;
        e.gre  = pat[7:0] & 8'((1 << c.cols) - 1);
        e.beep = ((k / (c.div + 1)) % 2) != 0;
        e.rep  = 1'b0;
        e.busy = 1'b1;
        return e;
    endfunction

    function automatic obs_t obs_a();
        obs_t o;
        o.hang = bus_a.hang;
        o.gre  = bus_a.gre;
        o.beep = bus_a.beep;
        o.rep  = bus_a.repeat_rst;
        o.busy = bus_a.busy;
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o.hang = bus_b.hang;
        o.gre  = bus_b.gre;
        o.beep = bus_b.beep;
        o.rep  = bus_b.repeat_rst;
        o.busy = bus_b.busy;
        return o;
    endfunction

    function automatic obs_t obs_c();
        obs_t o;
        o.hang = {4'b0000, bus_c.hang};
        o.gre  = {2'b00, bus_c.gre};
        o.beep = bus_c.beep;
        o.rep  = bus_c.repeat_rst;
        o.busy = bus_c.busy;
        return o;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus_a.success = 1'b0; bus_a.fail = 1'b0;
        bus_b.success = 1'b0; bus_b.fail = 1'b0;
        bus_c.success = 1'b0; bus_c.fail = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, want;
        rst = 1'b1;
        bus_a.success = 1'b0; bus_a.fail = 1'b0;
        bus_b.success = 1'b0; bus_b.fail = 1'b0;
        bus_c.success = 1'b0; bus_c.fail = 1'b0;
        sb.delete();
        sb.push_back(idle_exp(a_win));
        sb.push_back(idle_exp(b_win));
        sb.push_back(idle_exp(c_win));
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            got = (d == 0) ? obs_a() : (d == 1) ? obs_b() : obs_c();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset dut%0d got hang=%b gre=%h beep=%b rep=%b busy=%b want hang=%b gre=%h beep=%b rep=%b busy=%b",
                         d, got.hang, got.gre, got.beep, got.rep, got.busy,
                         want.hang, want.gre, want.beep, want.rep, want.busy);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_win_scan();
        obs_t got, want;
        do_reset();
        bus_a.success = 1'b1;
        for (int k = 0; k < 20; k++) sb.push_back(show_exp(a_win, k));
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            got = obs_a();
            checks++;
            want = (sb.size() != 0) ? sb.pop_front() : '1;
            if (got !== want) begin
                failures++;
                $display("FAIL win_scan k=%0d got hang=%b gre=%h beep=%b rep=%b busy=%b want hang=%b gre=%h beep=%b rep=%b busy=%b",
                         k, got.hang, got.gre, got.beep, got.rep, got.busy,
                         want.hang, want.gre, want.beep, want.rep, want.busy);
            end
        end
        bus_a.success = 1'b0;
    endtask

    task automatic test_reset_mid_show();
        obs_t got, want;
        do_reset();
        bus_a.success = 1'b1;
        for (int k = 0; k < 6; k++) sb.push_back(show_exp(a_win, k));
        sb.push_back(idle_exp(a_win));
        for (int k = 0; k < 4; k++) sb.push_back(show_exp(a_win, k));
        for (int n = 0; n < 11; n++) begin
            @(posedge clk); #1;
            got = obs_a();
            checks++;
            want = (sb.size() != 0) ? sb.pop_front() : '1;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_mid_show n=%0d got hang=%b gre=%h beep=%b rep=%b busy=%b want hang=%b gre=%h beep=%b rep=%b busy=%b",
                         n, got.hang, got.gre, got.beep, got.rep, got.busy,
                         want.hang, want.gre, want.beep, want.rep, want.busy);
            end
            rst = (n == 5);
        end
        bus_a.success = 1'b0;
    endtask

    task automatic test_both_triggers();
        obs_t got, want;
        do_reset();
        bus_a.success = 1'b1;
        bus_a.fail    = 1'b1;
        for (int k = 0; k < 31; k++) sb.push_back(show_exp(a_win, k));
        for (int k = 0; k < 31; k++) begin
            @(posedge clk); #1;
            got = obs_a();
            checks++;
            want = (sb.size() != 0) ? sb.pop_front() : '1;
            if (got !== want) begin
                failures++;
                $display("FAIL both_triggers k=%0d got hang=%b gre=%h beep=%b rep=%b busy=%b want hang=%b gre=%h beep=%b rep=%b busy=%b",
                         k, got.hang, got.gre, got.beep, got.rep, got.busy,
                         want.hang, want.gre, want.beep, want.rep, want.busy);
            end
        end
        bus_a.success = 1'b0;
        bus_a.fail    = 1'b0;
    endtask

    task automatic test_lose_hold();
        obs_t got, want;
        do_reset();
        bus_b.fail = 1'b1;
        for (int k = 0; k < 40; k++) sb.push_back(show_exp(b_lose, k));
        sb.push_back(done_exp(b_lose));
        sb.push_back(idle_exp(b_lose));
        sb.push_back(idle_exp(b_lose));
        for (int k = 0; k < 43; k++) begin
            @(posedge clk); #1;
            got = obs_b();
            checks++;
            want = (sb.size() != 0) ? sb.pop_front() : '1;
            if (got !== want) begin
                failures++;
                $display("FAIL lose_hold k=%0d got hang=%b gre=%h beep=%b rep=%b busy=%b want hang=%b gre=%h beep=%b rep=%b busy=%b",
                         k, got.hang, got.gre, got.beep, got.rep, got.busy,
                         want.hang, want.gre, want.beep, want.rep, want.busy);
            end
            if (k == 10) bus_b.fail = 1'b0;
        end
    endtask

    task automatic test_done_handshake();
        obs_t got, want;
        do_reset();
        bus_b.success = 1'b1;
        for (int k = 0; k < 40; k++) sb.push_back(show_exp(b_win, k));
        for (int k = 40; k < 48; k++) sb.push_back(done_exp(b_win));
        sb.push_back(idle_exp(b_win));
        for (int k = 0; k < 6; k++) sb.push_back(show_exp(b_lose, k));
        for (int n = 0; n < 55; n++) begin
            @(posedge clk); #1;
            got = obs_b();
            checks++;
            want = (sb.size() != 0) ? sb.pop_front() : '1;
            if (got !== want) begin
                failures++;
                $display("FAIL done_handshake n=%0d got hang=%b gre=%h beep=%b rep=%b busy=%b want hang=%b gre=%h beep=%b rep=%b busy=%b",
                         n, got.hang, got.gre, got.beep, got.rep, got.busy,
                         want.hang, want.gre, want.beep, want.rep, want.busy);
            end
            if (n == 47) bus_b.success = 1'b0;
            if (n == 48) bus_b.fail = 1'b1;
        end
        bus_b.fail = 1'b0;
    endtask

    task automatic test_small_matrix();
        obs_t got, want;
        do_reset();
        bus_c.success = 1'b1;
        for (int k = 0; k < 12; k++) sb.push_back(show_exp(c_win, k));
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            got = obs_c();
            checks++;
            want = (sb.size() != 0) ? sb.pop_front() : '1;
            if (got !== want) begin
                failures++;
                $display("FAIL small_matrix k=%0d got hang=%b gre=%h beep=%b rep=%b busy=%b want hang=%b gre=%h beep=%b rep=%b busy=%b",
                         k, got.hang, got.gre, got.beep, got.rep, got.busy,
                         want.hang, want.gre, want.beep, want.rep, want.busy);
            end
        end
        bus_c.success = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_a.success = 1'b0; bus_a.fail = 1'b0;
        bus_b.success = 1'b0; bus_b.fail = 1'b0;
        bus_c.success = 1'b0; bus_c.fail = 1'b0;
        test_reset();
        test_win_scan();
        test_reset_mid_show();
        test_both_triggers();
        test_lose_hold();
        test_done_handshake();
        test_small_matrix();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_matrix_face_player.md
Name: led_matrix_face_player

Overview:
- Parametrised end-of-game display player for the bomb-dismantlement board's row-scanned LED matrix and piezo buzzer.
- On a `success` or `fail` trigger it latches the result and scans the matching face pattern (smile or frown) row by row.
- While the face is shown it drives a mode-specific beep tone.
- After a fixed hold time it asserts `repeat_rst` so the top level can restart the game.
- Generalises the fixed 8x8 smile-only player with parametrised size, patterns, scan/beep rates, a lose mode and a clean handshake back to idle.

Parameters:
- ROWS, 8, number of matrix rows (row-select lines).
- COLS, 8, number of matrix columns (green data lines).
- WIN_PATTERN, 64'h0066666600422418, ROWS*COLS bits; row 0 = most significant COLS bits.
- LOSE_PATTERN, 64'h0066666600182442, same layout as WIN_PATTERN.
- SCAN_DIV, 1, clocks per row (>=1).
- WIN_BEEP_DIV, 10, beep toggles every WIN_BEEP_DIV+1 clocks in win mode.
- LOSE_BEEP_DIV, 23, beep toggles every LOSE_BEEP_DIV+1 clocks in lose mode.
- HOLD_CYCLES, 2500, clocks the face is displayed before `repeat_rst` (>=1).
- ROW_ACTIVE_LOW, 1, 1 = selected row driven 0 and others 1; 0 = inverted.

Ports:
- `clk` input 1 system clock; all logic on rising edge.
- `rst` input 1 reset, synchronous, active-high.
- `success` input 1 win trigger (level).
- `fail` input 1 lose trigger (level).
- `hang` output ROWS row select, registered.
- `gre` output COLS column data for the selected row, registered.
- `beep` output 1 buzzer square wave, registered.
- `repeat_rst` output 1 restart request, registered.
- `busy` output 1 high in any state other than IDLE.

Behaviour:
- Interface (decided): one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values (edge with `rst`=1, overriding everything incl. mid-display):
  - state=IDLE; row, scan, beep and hold counters = 0.
  - `hang`=all rows inactive (all 1s when ROW_ACTIVE_LOW=1); `gre`=0; `beep`=0; `repeat_rst`=0; `busy`=0.
- States: IDLE, SHOW_WIN, SHOW_LOSE, DONE.
- IDLE:
  - Outputs are held at their reset values.
  - `success`=1 -> SHOW_WIN. `fail`=1 (and `success`=0) -> SHOW_LOSE. Both high -> SHOW_WIN (`success` has priority).
  - On the transition edge: row=0, all counters=0, and `hang`/`gre` are loaded for row 0 (latency 1 clock from trigger sample to first row on the pins).
- SHOW_x:
  - Mode is latched; trigger inputs are ignored until DONE (deassertion does not abort).
  - Row r drive: `hang` = only bit ROWS-1-r active. `gre` = pattern[(ROWS-r)*COLS-1 -: COLS].
  - scan_cnt counts 0..SCAN_DIV-1. At SCAN_DIV-1 it clears and row advances; the row wraps ROWS-1 -> 0.
  - `beep`: beep_cnt counts 0..DIV. At DIV, `beep` toggles and beep_cnt clears. Half-period = DIV+1 clocks; DIV is the mode's divider.
  - hold_cnt increments every clock in SHOW. When hold_cnt==HOLD_CYCLES-1 -> DONE, so SHOW lasts exactly HOLD_CYCLES clocks.
- DONE:
  - `repeat_rst`=1; `hang` inactive; `gre`=0; `beep`=0; `busy`=1.
  - Stays in DONE while `success` or `fail` is high. Returns to IDLE the edge after both are sampled low; `repeat_rst` drops on that same edge.
- Widths:
  - Counter widths are $clog2 of (max value + 1), minimum 1 bit.
  - No counter overflows; all wrap explicitly as above.
- Column orientation: pattern bit COLS-1 of a row slice drives `gre`[COLS-1].

Test Plan:
- Reset then `success`=1 at edge 0 (defaults):
  - edge 0: `hang`=8'b01111111, `gre`=8'h00, `busy`=1.
  - edge 1: `hang`=8'b10111111, `gre`=8'h66.
  - edge 7: `hang`=8'b11111110, `gre`=8'h18.
  - edge 8: wraps to row 0.
- `fail` only, overrides HOLD_CYCLES=40, SCAN_DIV=2, LOSE_BEEP_DIV=3:
  - each row held 2 clocks; last row `gre`=8'h42.
  - `beep` toggles every 4 clocks.
  - `repeat_rst` rises exactly 40 clocks after entry.
- `success` and `fail` both 1 in IDLE -> WIN pattern shown; `beep` half-period 11 clocks (defaults).
- HOLD_CYCLES=40, `success` held high past hold:
  - `repeat_rst`=1 and outputs blank while `success`=1.
  - `success` low -> `repeat_rst`=0 and `busy`=0 one edge later; a new `fail` then starts SHOW_LOSE.
- `rst`=1 for one clock mid-SHOW_WIN at row 5 -> next edge: all outputs at reset values, state IDLE. With `success` still high after `rst` is released, display restarts at row 0.
- ROWS=4, COLS=6, ROW_ACTIVE_LOW=0, WIN_PATTERN=24'hFC0_03F, SCAN_DIV=1:
  - `hang` cycles 4'b1000, 0100, 0010, 0001.
  - `gre`=6'h3F, 6'h00, 6'h00, 6'h3F.
